// File: rtl/uart_ind_pkg.sv
// Shared constants for the UART indicator path: frame delimiter, parser state
// encoding and the default size of the digit register file.
package uart_ind_pkg;

  localparam logic [7:0] SOF_BYTE           = 8'hA5;
  localparam int         DEFAULT_NUM_DIGITS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    PAYLOAD  = 3'd3,
    GET_CHK  = 3'd4
  } state_e;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap counter. The count is the number of cycles since the last
// byte: a clear together with enable restarts at 1, a clear alone parks at 0.
module gap_timer #(
  parameter int TIMEOUT_CLKS  = 10400,
  parameter int TIMEOUT_WIDTH = 14
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] TERM = TIMEOUT_WIDTH'(TIMEOUT_CLKS - 1);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q;
    if (en_i) cnt_d = cnt_d + TIMEOUT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/uart_frame_controller.sv
// Parses [SOF, ADDR, LEN, payload, CHK] frames from the UART byte stream and
// commits the staged payload atomically into the digit registers on a good checksum.
module uart_frame_controller
  import uart_ind_pkg::*;
#(
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int ADDR_WIDTH    = 2,
  parameter int TIMEOUT_CLKS  = 10400,
  parameter int TIMEOUT_WIDTH = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [NUM_DIGITS*8-1:0] digits,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int         IW    = ADDR_WIDTH + 1;
  localparam logic [7:0] NUM_B = 8'(NUM_DIGITS);

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic [IW-1:0]                       len_q, len_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic [7:0]                          xor_acc_q, xor_acc_d;
  logic [NUM_DIGITS-1:0][7:0]          pay_q, pay_d;
  logic [NUM_DIGITS-1:0][7:0]          digits_q, digits_d;
  logic                                frame_ok_q, frame_ok_d;
  logic                                frame_err_q, frame_err_d;

  logic addr_ok, len_ok, last_payload, chk_ok;
  logic gap_clr, gap_en, gap_tc, timeout;

  assign addr_ok      = (rx_data < NUM_B);
  assign len_ok       = (rx_data != 8'd0) && (rx_data <= NUM_B);
  assign last_payload = (idx_q == len_q - IW'(1));
  assign chk_ok       = (rx_data == xor_acc_q);

  // A byte in the same cycle as the terminal count takes priority over the timeout.
  assign timeout = gap_tc && (state_q != IDLE) && !rx_valid;
  assign gap_clr = rx_valid || (state_d == IDLE);
  assign gap_en  = (state_d != IDLE);

  gap_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_gap (
    .clock(clock),
    .reset(reset),
    .clr_i(gap_clr),
    .en_i (gap_en),
    .tc_o (gap_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        IDLE:     if (rx_data == SOF_BYTE) state_d = GET_ADDR;
        GET_ADDR: state_d = addr_ok ? GET_LEN : IDLE;
        GET_LEN:  state_d = len_ok ? PAYLOAD : IDLE;
        PAYLOAD:  if (last_payload) state_d = GET_CHK;
        GET_CHK:  state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    xor_acc_d   = xor_acc_q;
    pay_d       = pay_q;
    digits_d    = digits_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        GET_ADDR: begin
          if (addr_ok) begin
            addr_d    = rx_data[ADDR_WIDTH-1:0];
            xor_acc_d = rx_data;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        GET_LEN: begin
          if (len_ok) begin
            len_d     = rx_data[IW-1:0];
            xor_acc_d = xor_acc_q ^ rx_data;
            idx_d     = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        PAYLOAD: begin
          pay_d[idx_q[ADDR_WIDTH-1:0]] = rx_data;
          xor_acc_d                    = xor_acc_q ^ rx_data;
          idx_d                        = idx_q + IW'(1);
        end
        GET_CHK: begin
          if (chk_ok) begin
            frame_ok_d = 1'b1;
            // Target slot wraps around the register file.
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (IW'(i) < len_q) digits_d[ADDR_WIDTH'(addr_q + ADDR_WIDTH'(i))] = pay_q[i];
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digits_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      xor_acc_q   <= 8'd0;
    end else begin
      digits_q    <= digits_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      xor_acc_q   <= xor_acc_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      pay_q       <= pay_d;
    end
  end

  assign digits    = digits_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_controller.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_uart_frame_controller;

  localparam int N = 4;
  localparam int T = 10400;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     rx_data = 8'd0;
  logic           rx_valid = 1'b0;
  logic [N*8-1:0] digits;
  logic           frame_ok, frame_err, busy;

  int   tests = 0, fails = 0;
  int   ok_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic ok_s, err_s;
  logic [7:0] mdig [N];

  uart_frame_controller dut (
    .clock    (clock),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .digits   (digits),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_ok === 1'b1)  ok_cnt  <= ok_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (frame_ok === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*8-1:0] packm();
    logic [N*8-1:0] p;
    for (int i = 0; i < N; i++) p[i*8 +: 8] = mdig[i];
    return p;
  endfunction

  // Frame-level reference: decides where the frame ends and whether it commits.
  function automatic void model(input logic [7:0] f[$], output int last, output bit ok);
    int a, l;
    logic [7:0] x;
    ok = 1'b0;
    a  = int'(f[1]);
    if (a >= N) begin last = 1; return; end
    l = int'(f[2]);
    if (l < 1 || l > N) begin last = 2; return; end
    x = f[1] ^ f[2];
    for (int i = 0; i < l; i++) x ^= f[3+i];
    last = 3 + l;
    if (f[last] == x) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) mdig[(a + i) % N] = f[3+i];
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    ok_s     = frame_ok;
    err_s    = frame_err;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$]);
    int last, ok0, err0, ok_at, err_at;
    bit ok;
    model(f, last, ok);
    ok0 = ok_cnt; err0 = err_cnt; ok_at = -1; err_at = -1;
    for (int k = 0; k <= last; k++) begin
      send_byte(f[k]);
      if (ok_s === 1'b1)  ok_at  = k;
      if (err_s === 1'b1) err_at = k;
    end
    idle(2);
    check({tag, "_ok_n"},   64'(ok_cnt - ok0),   64'(ok));
    check({tag, "_err_n"},  64'(err_cnt - err0), 64'(!ok));
    check({tag, "_at"},     64'(ok ? ok_at : err_at), 64'(last));
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_digits"}, 64'(digits), 64'(packm()));
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] b, x;
    int k, ok0, err0, last, a, l;
    bit okm;

    for (int i = 0; i < N; i++) mdig[i] = 8'd0;

    idle(3);
    check("rst_digits", 64'(digits), 64'd0);
    check("rst_ok",     64'(frame_ok), 64'd0);
    check("rst_err",    64'(frame_err), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    reset = 1'b0;
    idle(1);

    f = {8'hA5, 8'h01, 8'h02, 8'h3F, 8'h06, 8'h3A};
    run_frame("basic", f);
    check("basic_const", 64'(digits), 64'h00063F00);

    f = {8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32};
    run_frame("wrap", f);
    check("wrap_const", 64'(digits), 64'h11063F22);

    f = {8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33};
    run_frame("badchk", f);
    check("badchk_const", 64'(digits), 64'h11063F22);

    f = {8'hA5, 8'h00, 8'h00};
    run_frame("len0", f);
    f = {8'hA5, 8'h04};
    run_frame("badaddr", f);

    // Silence after ADDR: error appears T cycles after the ADDR byte.
    err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    k = 1;
    while (frame_err !== 1'b1 && k < T + 8) begin @(posedge clock); #1; k++; end
    check("to_latency", 64'(k), 64'(T));
    idle(2);
    check("to_err_n",  64'(err_cnt - err0), 64'd1);
    check("to_busy",   64'(busy), 64'd0);
    check("to_digits", 64'(digits), 64'(packm()));

    // Byte landing exactly on the terminal count keeps the frame alive.
    f = {8'hA5, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30};
    model(f, last, okm);
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    k = 1;
    while (k < T - 1) begin @(posedge clock); #1; k++; end
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    idle(2);
    check("tc_err_n",  64'(err_cnt - err0), 64'd0);
    check("tc_ok_n",   64'(ok_cnt - ok0), 64'd1);
    check("tc_const",  64'(digits), 64'h20103F22);
    check("tc_digits", 64'(digits), 64'(packm()));

    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'h3F);
    check("junk_busy0", 64'(busy), 64'd0);
    send_byte(8'h00);
    check("junk_busy1", 64'(busy), 64'd0);
    idle(1);
    check("junk_pulses", 64'((ok_cnt - ok0) + (err_cnt - err0)), 64'd0);

    f = {8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
    run_frame("sofdata_bad", f);
    f = {8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA4};
    run_frame("sofdata", f);
    check("sofdata_d0", 64'(digits[7:0]), 64'hA5);

    // Reset in the middle of a frame, just after its payload byte.
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h77);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mdig[i] = 8'd0;
    idle(2);
    check("mrst_digits", 64'(digits), 64'd0);
    check("mrst_busy",   64'(busy), 64'd0);
    check("mrst_pulses", 64'((ok_cnt - ok0) + (err_cnt - err0)), 64'd0);
    f = {8'hA5, 8'h02, 8'h01, 8'h5C, 8'h5F};
    run_frame("post_rst", f);
    check("post_rst_const", 64'(digits), 64'h005C0000);

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
      end
      idle($urandom_range(0, 3));
      a = $urandom_range(0, 4);
      l = ($urandom_range(0, 7) == 0) ? 5 * $urandom_range(0, 1) : $urandom_range(1, 4);
      f = {8'hA5, 8'(a), 8'(l)};
      x = 8'(a) ^ 8'(l);
      for (int i = 0; i < l && i < N; i++) begin
        b = 8'($urandom);
        f.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      f.push_back(x);
      run_frame("rand", f);
    end

    check("no_overlap", 64'(both_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
